// File: rtl/if_id_pipe_pkg.sv
// Shared pipeline constants and entry record for the IF/ID pipeline register.
// The helper counts how many instructions a flush throws away.
package if_id_pipe_pkg;

  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_W    = 8;
  localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = '0;

  typedef struct packed {
    logic                   valid;
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0]    pc;
  } entry_t;

  // Held entries minus the one ID takes this cycle, plus any beat arriving now.
  // An input beat implies an empty skid, and an output beat implies a full
  // main, so the result never exceeds 2 and never underflows.
  function automatic logic [1:0] discard_count(input logic main_v,
                                               input logic skid_v,
                                               input logic out_xfer,
                                               input logic in_xfer);
    return 2'(main_v) + 2'(skid_v) - 2'(out_xfer) + 2'(in_xfer);
  endfunction

endpackage

// File: rtl/if_id_pipe_if.sv
// IF/ID handshake bundle: upstream valid/ready, downstream valid/ready,
// flush and the flush statistics counter.
interface if_id_pipe_if
  import if_id_pipe_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int CNT_W   = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [CNT_W-1:0]   flush_cnt;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, flush_cnt
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, flush_cnt
  );

endinterface

// File: rtl/if_id_pipe_sat_counter.sv
// Saturating up-counter that adds a small increment when enabled.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [1:0]   inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W:0] sum;

  // One extra bit is enough: the increment is at most 3.
  assign sum = {1'b0, count} + (W+1)'(inc);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= sum[W] ? MAX : sum[W-1:0];
    end
  end

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with a skid entry for a registered in_ready,
// flush priority over all transfers, and a saturating flush statistic.
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter int                 PC_W      = DEF_PC_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
  parameter int                 CNT_W     = 16
) (
  input  logic          clock,
  input  logic          reset,
  if_id_pipe_if.slave   bus
);

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } slot_t;

  slot_t      main_q;
  slot_t      main_n;
  slot_t      skid_q;
  slot_t      skid_n;
  slot_t      in_slot;
  logic       in_ready_q;
  logic       in_xfer;
  logic       out_xfer;
  logic [1:0] drop_n;

  always_comb begin
    in_xfer        = bus.in_valid & in_ready_q;
    out_xfer       = main_q.valid & bus.out_ready;
    in_slot.valid  = 1'b1;
    in_slot.instr  = bus.in_instr;
    in_slot.pc     = bus.in_pc;
    main_n         = main_q;
    skid_n         = skid_q;
    drop_n         = discard_count(main_q.valid, skid_q.valid, out_xfer, in_xfer);

    // Flush only clears valid bits; main.pc keeps showing the last PC.
    if (bus.flush) begin
      main_n.valid = 1'b0;
      skid_n.valid = 1'b0;
    end else if (out_xfer) begin
      if (skid_q.valid) begin
        main_n       = skid_q;
        skid_n.valid = 1'b0;
      end else if (in_xfer) begin
        main_n = in_slot;
      end else begin
        main_n.valid = 1'b0;
      end
    end else if (in_xfer) begin
      if (main_q.valid) begin
        skid_n = in_slot;
      end else begin
        main_n = in_slot;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_q.valid <= 1'b0;
      main_q.instr <= NOP_INSTR;
      main_q.pc    <= '0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q     <= main_n;
      skid_q     <= skid_n;
      in_ready_q <= ~skid_n.valid;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_q.valid;
  assign bus.out_instr = main_q.valid ? main_q.instr : NOP_INSTR;
  assign bus.out_pc    = main_q.pc;

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .en    (bus.flush),
    .inc   (drop_n),
    .count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_if_id_pipe.sv
// Scoreboard bench for if_id_pipe: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_if_id_pipe;
  import if_id_pipe_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } item_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  if_id_pipe_if #(.INSTR_W(32), .PC_W(8), .CNT_W(16)) bm ();
  if_id_pipe_if #(.INSTR_W(32), .PC_W(8), .CNT_W(2))  bs ();

  if_id_pipe #(.INSTR_W(32), .PC_W(8), .NOP_INSTR(32'h0), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bm.slave)
  );

  if_id_pipe #(.INSTR_W(32), .PC_W(8), .NOP_INSTR(32'h0), .CNT_W(2)) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (bs.slave)
  );

  assign bs.in_valid  = bm.in_valid;
  assign bs.in_instr  = bm.in_instr;
  assign bs.in_pc     = bm.in_pc;
  assign bs.flush     = bm.flush;
  assign bs.out_ready = bm.out_ready;

  always #5 clock = ~clock;

  item_t sbq[$];
  logic [7:0] mpc;
  int unsigned cnt16;
  int unsigned cnt2;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, check registered outputs against the model, advance model.
  task automatic cycle(input logic iv, input logic [7:0] ipc, input logic ordy, input logic fl);
    logic [31:0] ins;
    logic in_x, out_x;
    item_t it;
    int unsigned d;
    @(negedge clock);
    ins          = $urandom;
    reset        = 1'b0;
    bm.in_valid  = iv;
    bm.in_pc     = ipc;
    bm.in_instr  = ins;
    bm.out_ready = ordy;
    bm.flush     = fl;
    #1;
    chk("in_ready",  64'(bm.in_ready),  64'((sbq.size() < 2) ? 1 : 0));
    chk("out_valid", 64'(bm.out_valid), 64'((sbq.size() > 0) ? 1 : 0));
    chk("out_pc",    64'(bm.out_pc),    64'(mpc));
    chk("out_instr", 64'(bm.out_instr), (sbq.size() > 0) ? 64'(sbq[0].instr) : 64'h0);
    chk("flush_cnt", 64'(bm.flush_cnt), 64'(cnt16));
    chk("flush_cnt_sat", 64'(bs.flush_cnt), 64'(cnt2));
    in_x  = iv && (sbq.size() < 2);
    out_x = ordy && (sbq.size() > 0);
    if (out_x) begin
      it = sbq.pop_front();
      chk("sb_pc", 64'(bm.out_pc), 64'(it.pc));
    end
    if (in_x) begin
      it.instr = ins;
      it.pc    = ipc;
      sbq.push_back(it);
    end
    if (fl) begin
      d = sbq.size();
      cnt16 = (cnt16 + d > 65535) ? 65535 : cnt16 + d;
      cnt2  = (cnt2 + d > 3) ? 3 : cnt2 + d;
      sbq.delete();
    end
    if (sbq.size() > 0) mpc = sbq[0].pc;
  endtask

  // Reset with every other input asserted, proving reset wins.
  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    bm.in_valid  = 1'b1;
    bm.in_pc     = 8'hEE;
    bm.in_instr  = 32'hDEAD_BEEF;
    bm.out_ready = 1'b1;
    bm.flush     = 1'b1;
    @(posedge clock);
    sbq.delete();
    mpc   = 8'h0;
    cnt16 = 0;
    cnt2  = 0;
  endtask

  initial begin
    bm.in_valid  = 1'b0;
    bm.in_pc     = 8'h0;
    bm.in_instr  = 32'h0;
    bm.out_ready = 1'b0;
    bm.flush     = 1'b0;
    do_reset();
    do_reset();

    // Streaming, one beat per cycle
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 8'h0, 1'b1, 1'b0);

    // Stall into the skid entry, then drain
    cycle(1'b1, 8'd5, 1'b0, 1'b0);
    cycle(1'b1, 8'd6, 1'b0, 1'b0);
    cycle(1'b1, 8'd99, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'h0, 1'b1, 1'b0);

    // Flush with both entries full
    cycle(1'b1, 8'd7, 1'b0, 1'b0);
    cycle(1'b1, 8'd8, 1'b0, 1'b0);
    cycle(1'b0, 8'h0, 1'b0, 1'b1);
    cycle(1'b0, 8'h0, 1'b1, 1'b0);

    // Flush with simultaneous input and output beats
    cycle(1'b1, 8'd10, 1'b0, 1'b0);
    cycle(1'b1, 8'd11, 1'b1, 1'b1);
    cycle(1'b0, 8'h0, 1'b1, 1'b0);

    // Repeated double-entry flushes drive the narrow counter to saturation
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'(20 + 2*k), 1'b0, 1'b0);
      cycle(1'b1, 8'(21 + 2*k), 1'b0, 1'b0);
      cycle(1'b0, 8'h0, 1'b0, 1'b1);
    end
    cycle(1'b0, 8'h0, 1'b0, 1'b0);

    // Random traffic with occasional flushes
    for (int r = 0; r < 300; r++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));

    // Reset while stalled with both entries full, then a fresh beat
    cycle(1'b1, 8'd12, 1'b0, 1'b0);
    cycle(1'b1, 8'd13, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 8'd9, 1'b0, 1'b0);
    cycle(1'b0, 8'h0, 1'b1, 1'b0);
    cycle(1'b0, 8'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter INSTR_W, default 32: instruction width in bits.
REQ-002 Parameter PC_W, default 8: next-PC width in bits.
REQ-003 Parameter NOP_INSTR, default 0 (INSTR_W bits): instruction value presented while no valid entry is held.
REQ-004 Parameter CNT_W, default 16: width of the flush statistics counter.
REQ-005 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  reset; synchronous, active-high.
REQ-007 in_valid  input  1  the IF stage offers an instruction this cycle.
REQ-008 in_ready  output  1  the block accepts an offered instruction this cycle.
REQ-009 in_instr  input  INSTR_W  fetched instruction.
REQ-010 in_pc  input  PC_W  next-PC paired with in_instr.
REQ-011 flush  input  1  discard all held and incoming instructions (branch/jump taken).
REQ-012 out_valid  output  1  the ID stage is offered an instruction.
REQ-013 out_ready  input  1  the ID stage consumes the offered instruction; low means stall.
REQ-014 out_instr  output  INSTR_W  instruction presented to ID.
REQ-015 out_pc  output  PC_W  next-PC presented to ID.
REQ-016 flush_cnt  output  CNT_W  saturating count of valid instructions discarded by flush.

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid; each entry holds instr, pc and a valid bit.
REQ-018 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-019 in_ready SHALL be a register output equal to NOT skid.valid, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal main.valid; out_instr SHALL equal main.instr when main.valid is high, else NOP_INSTR; out_pc SHALL equal main.pc.
REQ-021 Main empty and input transfer: main SHALL load the input; latency 1 cycle.
REQ-022 Main full, output transfer, input transfer, skid empty: main SHALL load the input (full throughput, one beat per cycle).
REQ-023 Main full, no output transfer, input transfer: skid SHALL load the input; in_ready SHALL be low in the following cycle.
REQ-024 Skid full and output transfer: main SHALL load skid; skid SHALL empty; in_ready SHALL be high in the following cycle.
REQ-025 Main full and no output transfer: main SHALL hold instr and pc unchanged (stall).
REQ-026 Order SHALL be preserved; no instruction SHALL be dropped or duplicated except by flush.
REQ-027 flush SHALL have priority over every transfer: next cycle both valid bits SHALL be 0 and any same-cycle input beat SHALL be discarded; main.pc SHALL hold its value.
REQ-028 A same-cycle output transfer during flush SHALL still count as consumed by ID; only entries not consumed SHALL be counted as discarded.
REQ-029 On flush, flush_cnt SHALL add the number of discarded valid entries (0, 1 or 2) plus 1 if an input transfer occurred that cycle, saturating at 2^CNT_W-1.
REQ-030 out_pc and out_instr SHALL be stable while out_valid is high and out_ready is low.

Reset
REQ-031 With reset high at a rising edge, the next state SHALL be: main.valid=0, skid.valid=0, main.pc=0, main.instr=NOP_INSTR, flush_cnt=0, in_ready=1.
REQ-032 reset SHALL override flush and all transfers, including mid-stall with both entries full.

Structure
REQ-033 Defaults for INSTR_W, PC_W and NOP_INSTR SHALL be taken from the shared pipeline constants package, which also carries the entry record typedef (valid, instr, pc).
REQ-034 The flush_cnt saturating counter SHALL be a sub-module named sat_counter, parameterised by width.

Verification
REQ-035 Streaming: out_ready=1; 4 beats pc=1..4 on consecutive cycles -> out_pc=1..4 on consecutive cycles, each 1 cycle after input; in_ready stays 1.
REQ-036 Stall/skid: main holds pc=5, out_ready=0, beat pc=6 accepted -> in_ready=0 next cycle; raising out_ready -> outputs pc=5 then pc=6, with in_ready=1 one cycle after pc=5 is consumed.
REQ-037 Flush: both entries full (pc=7, pc=8), out_ready=0, flush=1 -> next cycle out_valid=0, out_instr=NOP_INSTR, out_pc=7, flush_cnt=2.
REQ-038 Flush with same-cycle input transfer and output transfer: main full, skid empty, in_valid=1, out_ready=1, flush=1 -> out_valid=0 next cycle, flush_cnt increments by 1.
REQ-039 Saturation: CNT_W=2; apply 3 double-entry flushes -> flush_cnt=3 and held there.
REQ-040 Reset mid-stall: both entries full, reset=1 for one cycle -> all REQ-031 values; a new beat pc=9 then appears at the outputs 1 cycle after it is accepted.
